bus_arbiter: RTL

Two-master arbiter placed in front of the address-decode bus so the microprocessor and a second master (the UART boot/DMA loader) share the RAM and peripheral map. It holds the grant state, multiplexes the owning master's address, write enable and write data onto the single bus, and returns read data and acknowledges to the owner. Arbitration is round-robin with a bounded burst length, so neither master can starve the other.

---
 rtl/bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a bounded burst length.
// Grants, bus mux and read-data return are all steered from the registered owner state.
module bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_gnt_o,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_gnt_o,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic [ADDR_W-1:0] bus_addr_o,
    output logic              bus_we_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [1:0]        owner_o
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    // Encodings double as the owner_o value.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_M0 = 2'b01,
        OWN_M1 = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             last_owner_q, last_owner_d;   // 0 = m0, 1 = m1

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;

        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (m0_req_i && (!m1_req_i || last_owner_q)) begin
                    state_d = OWN_M0;
                end else if (m1_req_i) begin
                    state_d = OWN_M1;
                end
            end
            OWN_M0: begin
                if (!m0_req_i) begin
                    state_d = m1_req_i ? OWN_M1 : IDLE;
                end else if (m1_req_i && (burst_cnt_q == BURST_LAST)) begin
                    state_d = OWN_M1;
                end else if (burst_cnt_q != BURST_LAST) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            OWN_M1: begin
                if (!m1_req_i) begin
                    state_d = m0_req_i ? OWN_M0 : IDLE;
                end else if (m0_req_i && (burst_cnt_q == BURST_LAST)) begin
                    state_d = OWN_M0;
                end else if (burst_cnt_q != BURST_LAST) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Any change of owner restarts the burst and records who got the bus.
        if (state_d != state_q) begin
            burst_cnt_d = '0;
            if (state_d == OWN_M0) last_owner_d = 1'b0;
            if (state_d == OWN_M1) last_owner_d = 1'b1;
        end
    end

    always_comb begin
        m0_gnt_o   = 1'b0;
        m1_gnt_o   = 1'b0;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_rdata_o = '0;
        m1_rdata_o = '0;
        bus_addr_o = '0;
        bus_data_o = '0;
        bus_we_o   = 1'b0;
        owner_o    = state_q;

        case (state_q)
            OWN_M0: begin
                m0_gnt_o   = 1'b1;
                m0_ack_o   = m0_req_i;
                m0_rdata_o = bus_rdata_i;
                bus_addr_o = m0_addr_i;
                bus_data_o = m0_data_i;
                bus_we_o   = m0_we_i & m0_req_i;
            end
            OWN_M1: begin
                m1_gnt_o   = 1'b1;
                m1_ack_o   = m1_req_i;
                m1_rdata_o = bus_rdata_i;
                bus_addr_o = m1_addr_i;
                bus_data_o = m1_data_i;
                bus_we_o   = m1_we_i & m1_req_i;
            end
            default: ;
        endcase
    end

endmodule
